// File: rtl/gru_fxp_pkg.sv
// Shared fixed-point definitions for the GRU datapath: default widths, accumulator sizing,
// saturation limits and the dense-head FSM state encoding.
package gru_fxp_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_FRAC_BITS  = 16;

    // Saturation limits at the default word width
    localparam logic signed [DEF_DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DEF_DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DEF_DATA_WIDTH-1:0] MAX_NEG = {1'b1, {(DEF_DATA_WIDTH-1){1'b0}}};

    // Full-precision product width plus growth for `units` terms plus one bit for the bias term
    function automatic int unsigned acc_width(int unsigned dw, int unsigned units);
        return 2 * dw + $clog2(units) + 1;
    endfunction

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_BIAS,
        S_ROUND,
        S_OUT
    } gru_state_e;

endpackage

// File: rtl/fxp_round_sat.sv
// Combinational round-half-up, arithmetic shift by FRAC_BITS and saturation of a wide
// accumulator down to a DATA_WIDTH signed word.
module fxp_round_sat
    import gru_fxp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned FRAC_BITS  = DEF_FRAC_BITS,
    parameter int unsigned ACC_W      = acc_width(DATA_WIDTH, 3)
) (
    input  logic signed [ACC_W-1:0]      acc_i,
    output logic signed [DATA_WIDTH-1:0] y_o
);

    // One extra bit so adding the half-LSB can never wrap
    localparam logic signed [ACC_W:0] Half = {{ACC_W{1'b0}}, 1'b1} << (FRAC_BITS - 1);

    logic signed [DATA_WIDTH-1:0] sat_pos;
    logic signed [DATA_WIDTH-1:0] sat_neg;
    logic signed [ACC_W:0]        biased;
    logic signed [ACC_W:0]        shifted;

    if (DATA_WIDTH == DEF_DATA_WIDTH) begin : g_pkg_lim
        assign sat_pos = MAX_POS;
        assign sat_neg = MAX_NEG;
    end else begin : g_gen_lim
        assign sat_pos = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        assign sat_neg = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end

    // Round half up, drop fraction bits, clamp into the representable range
    always_comb begin
        biased  = {acc_i[ACC_W-1], acc_i} + Half;
        shifted = biased >>> FRAC_BITS;
        if (shifted > (ACC_W+1)'(sat_pos)) begin
            y_o = sat_pos;
        end else if (shifted < (ACC_W+1)'(sat_neg)) begin
            y_o = sat_neg;
        end else begin
            y_o = shifted[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/gru_dense_head.sv
// Dense output projection after the GRU: y = sum(Wd[i]*h[i]) + bd, one multiply per cycle,
// rounded and saturated, delivered over valid/ready with a per-sequence last flag.
module gru_dense_head
    import gru_fxp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned FRAC_BITS  = DEF_FRAC_BITS,
    parameter int unsigned GRU_UNITS  = 3,
    parameter int unsigned SEQ_LENGTH = 4
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              i_w_we,
    input  logic [$clog2(GRU_UNITS+1)-1:0]    i_w_addr,
    input  logic [DATA_WIDTH-1:0]             i_w_data,
    output logic                              o_w_drop,
    input  logic                              i_seq_clear,
    input  logic                              i_h_valid,
    input  logic [GRU_UNITS*DATA_WIDTH-1:0]   i_h_flat,
    output logic                              o_h_ready,
    output logic                              o_y_valid,
    output logic [DATA_WIDTH-1:0]             o_y_data,
    output logic                              o_y_last,
    input  logic                              i_y_ready,
    output logic                              o_busy
);

    localparam int unsigned AccW  = acc_width(DATA_WIDTH, GRU_UNITS);
    localparam int unsigned AddrW = $clog2(GRU_UNITS + 1);
    localparam int unsigned KW    = (GRU_UNITS > 1) ? $clog2(GRU_UNITS) : 1;
    localparam int unsigned TW    = (SEQ_LENGTH > 1) ? $clog2(SEQ_LENGTH) : 1;

    gru_state_e                   state_q;
    logic [KW-1:0]                k_q;
    logic [TW-1:0]                tcount_q, tcount_d;
    logic signed [DATA_WIDTH-1:0] wd_q [GRU_UNITS];
    logic signed [DATA_WIDTH-1:0] bd_q;
    logic signed [DATA_WIDTH-1:0] h_q [GRU_UNITS];
    logic signed [AccW-1:0]       acc_q;
    logic [DATA_WIDTH-1:0]        y_data_q;
    logic                         y_valid_q, y_last_q, w_drop_q;

    logic                         idle, w_accept;
    logic signed [DATA_WIDTH-1:0] w_sel, h_sel;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [DATA_WIDTH-1:0] y_round;

    assign idle      = (state_q == S_IDLE);
    // A vector arriving in the same cycle takes priority over a weight write
    assign w_accept  = i_w_we && idle && !i_h_valid && (32'(i_w_addr) <= GRU_UNITS);

    assign o_h_ready = idle;
    assign o_busy    = !idle;
    assign o_y_valid = y_valid_q;
    assign o_y_data  = y_data_q;
    assign o_y_last  = y_last_q;
    assign o_w_drop  = w_drop_q;

    // Select the k-th weight/hidden pair and form the full-precision product
    always_comb begin
        w_sel = '0;
        h_sel = '0;
        for (int i = 0; i < GRU_UNITS; i++) begin
            if (k_q == KW'(i)) begin
                w_sel = wd_q[i];
                h_sel = h_q[i];
            end
        end
        prod = (2*DATA_WIDTH)'(w_sel) * (2*DATA_WIDTH)'(h_sel);
    end

    // Timestep counter: advance on output handshake, clear wins over advance
    always_comb begin
        tcount_d = tcount_q;
        if (state_q == S_OUT && i_y_ready) begin
            tcount_d = (tcount_q == TW'(SEQ_LENGTH - 1)) ? '0 : tcount_q + 1'b1;
        end
        if (i_seq_clear) begin
            tcount_d = '0;
        end
    end

    fxp_round_sat #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS),
        .ACC_W      (AccW)
    ) u_round_sat (
        .acc_i (acc_q),
        .y_o   (y_round)
    );

    // Weight and bias storage, written only while idle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < GRU_UNITS; i++) wd_q[i] <= '0;
            bd_q <= '0;
        end else if (w_accept) begin
            if (i_w_addr == AddrW'(GRU_UNITS)) begin
                bd_q <= i_w_data;
            end
            for (int i = 0; i < GRU_UNITS; i++) begin
                if (i_w_addr == AddrW'(i)) wd_q[i] <= i_w_data;
            end
        end
    end

    // Control FSM with MAC datapath and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            acc_q     <= '0;
            tcount_q  <= '0;
            y_data_q  <= '0;
            y_valid_q <= 1'b0;
            y_last_q  <= 1'b0;
            w_drop_q  <= 1'b0;
            for (int i = 0; i < GRU_UNITS; i++) h_q[i] <= '0;
        end else begin
            w_drop_q <= i_w_we && !w_accept;
            tcount_q <= tcount_d;
            unique case (state_q)
                S_IDLE: begin
                    if (i_h_valid) begin
                        for (int i = 0; i < GRU_UNITS; i++) begin
                            h_q[i] <= i_h_flat[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                        acc_q   <= '0;
                        k_q     <= '0;
                        state_q <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc_q <= acc_q + AccW'(prod);
                    if (k_q == KW'(GRU_UNITS - 1)) begin
                        state_q <= S_BIAS;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                S_BIAS: begin
                    // Bias is Q-format like the inputs; align it to the product scale
                    acc_q   <= acc_q + (AccW'(bd_q) <<< FRAC_BITS);
                    state_q <= S_ROUND;
                end
                S_ROUND: begin
                    y_data_q  <= y_round;
                    y_valid_q <= 1'b1;
                    y_last_q  <= (tcount_q == TW'(SEQ_LENGTH - 1));
                    state_q   <= S_OUT;
                end
                S_OUT: begin
                    if (i_y_ready) begin
                        y_valid_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gru_dense_head.sv
// Self-checking bench for gru_dense_head: directed cases plus randomized traffic compared
// against an arithmetic reference model of the dense projection.
module tb_gru_dense_head;

    localparam int DW  = 32;
    localparam int FB  = 16;
    localparam int NU  = 3;
    localparam int SL  = 4;
    localparam int AWW = $clog2(NU + 1);

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              i_w_we = 1'b0;
    logic [AWW-1:0]    i_w_addr = '0;
    logic [DW-1:0]     i_w_data = '0;
    logic              o_w_drop;
    logic              i_seq_clear = 1'b0;
    logic              i_h_valid = 1'b0;
    logic [NU*DW-1:0]  i_h_flat = '0;
    logic              o_h_ready;
    logic              o_y_valid;
    logic [DW-1:0]     o_y_data;
    logic              o_y_last;
    logic              i_y_ready = 1'b0;
    logic              o_busy;

    gru_dense_head #(
        .DATA_WIDTH (DW),
        .FRAC_BITS  (FB),
        .GRU_UNITS  (NU),
        .SEQ_LENGTH (SL)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_w_we      (i_w_we),
        .i_w_addr    (i_w_addr),
        .i_w_data    (i_w_data),
        .o_w_drop    (o_w_drop),
        .i_seq_clear (i_seq_clear),
        .i_h_valid   (i_h_valid),
        .i_h_flat    (i_h_flat),
        .o_h_ready   (o_h_ready),
        .o_y_valid   (o_y_valid),
        .o_y_data    (o_y_data),
        .o_y_last    (o_y_last),
        .i_y_ready   (i_y_ready),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: loaded weights, bias, position in sequence, pending results
    logic signed [DW-1:0] mw [NU];
    logic signed [DW-1:0] mbd;
    int                   mt;
    logic [DW-1:0]        exp_q [$];
    bit                   expl_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [NU*DW-1:0] pack3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                               input logic [DW-1:0] c);
        return {c, b, a};
    endfunction

    // y = round_half_up((sum w*h + bd*2^FB) / 2^FB), clamped to the signed word range
    function automatic logic [DW-1:0] model_y(input logic [NU*DW-1:0] hf);
        logic signed [127:0] s, hi, lo;
        logic signed [DW-1:0] hv;
        s = '0;
        for (int i = 0; i < NU; i++) begin
            hv = hf[i*DW +: DW];
            s  = s + 128'(mw[i]) * 128'(hv);
        end
        s  = s + 128'(mbd) * (128'sd1 <<< FB);
        s  = (s + (128'sd1 <<< (FB - 1))) >>> FB;
        hi = (128'sd1 <<< (DW - 1)) - 128'sd1;
        lo = -(128'sd1 <<< (DW - 1));
        if (s > hi) s = hi;
        if (s < lo) s = lo;
        return s[DW-1:0];
    endfunction

    // Every cycle a result is presented it must equal the oldest outstanding expectation
    always @(negedge clk) begin
        if (rstn && o_y_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got o_y_valid=1, expected no pending result");
            end else begin
                check("y_data", o_y_data, exp_q[0]);
                check("y_last", o_y_last, expl_q[0]);
                check("h_ready_while_out", o_h_ready, 0);
                if (i_y_ready) begin
                    void'(exp_q.pop_front());
                    void'(expl_q.pop_front());
                    mt = (mt + 1) % SL;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input logic [DW-1:0] d, input bit exp_drop);
        i_w_we   = 1'b1;
        i_w_addr = AWW'(addr);
        i_w_data = d;
        tick();
        i_w_we = 1'b0;
        if (!exp_drop) begin
            if (addr == NU) mbd = d;
            else mw[addr] = d;
        end
        check("w_drop", o_w_drop, exp_drop);
    endtask

    task automatic seq_clear();
        i_seq_clear = 1'b1;
        tick();
        i_seq_clear = 1'b0;
        mt = 0;
    endtask

    task automatic send_start(input logic [NU*DW-1:0] hf, input bit with_wr,
                              output logic [DW-1:0] y, output logic l);
        int n;
        n = 0;
        while (!o_h_ready && n < 50) begin
            tick();
            n++;
        end
        check("h_ready_before_send", o_h_ready, 1);
        exp_q.push_back(model_y(hf));
        expl_q.push_back(mt == SL - 1);
        i_h_valid = 1'b1;
        i_h_flat  = hf;
        if (with_wr) begin
            i_w_we   = 1'b1;
            i_w_addr = AWW'($urandom_range(0, NU));
            i_w_data = $urandom;
        end
        tick();
        i_h_valid = 1'b0;
        i_w_we    = 1'b0;
        if (with_wr) check("w_drop_vs_hvalid", o_w_drop, 1);
        check("busy_after_accept", o_busy, 1);
        n = 1;
        while (!o_y_valid && n < 50) begin
            tick();
            n++;
        end
        check("latency", n, NU + 3);
        y = o_y_data;
        l = o_y_last;
    endtask

    task automatic finish_vec(input int d, input bit try_wr);
        for (int i = 0; i < d; i++) begin
            if (try_wr && i == 2) wr($urandom_range(0, NU), $urandom, 1'b1);
            else tick();
            check("busy_while_stalled", o_busy, 1);
        end
        i_y_ready = 1'b1;
        tick();
        i_y_ready = 1'b0;
        check("y_valid_cleared", o_y_valid, 0);
        check("h_ready_after_out", o_h_ready, 1);
        check("busy_after_out", o_busy, 0);
    endtask

    task automatic run_vec(input logic [NU*DW-1:0] hf, input int d, output logic [DW-1:0] y,
                           output logic l);
        send_start(hf, 1'b0, y, l);
        finish_vec(d, 1'b0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NU; i++) mw[i] = '0;
        mbd = '0;
        mt  = 0;
        exp_q.delete();
        expl_q.delete();
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] r;
        r = $urandom;
        if ($urandom_range(0, 3) != 0) r = $signed(r) >>> $urandom_range(8, 16);
        return r;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] y;
        logic          l;
        logic [NU*DW-1:0] hb;
        bit lasts [5];

        model_reset();
        tick();
        tick();
        check("rst_h_ready", o_h_ready, 1);
        check("rst_y_valid", o_y_valid, 0);
        check("rst_y_data", o_y_data, 0);
        check("rst_y_last", o_y_last, 0);
        check("rst_w_drop", o_w_drop, 0);
        check("rst_busy", o_busy, 0);
        rstn = 1'b1;
        tick();

        // Basic MAC: 1*1 + 2*1 - 0.5*2 + 0.25 = 2.25
        wr(0, 32'h0001_0000, 1'b0);
        wr(1, 32'h0002_0000, 1'b0);
        wr(2, 32'hFFFF_8000, 1'b0);
        wr(3, 32'h0000_4000, 1'b0);
        hb = pack3(32'h0001_0000, 32'h0001_0000, 32'h0002_0000);
        check("model_basic", model_y(hb), 32'h0002_4000);
        run_vec(hb, 0, y, l);
        check("basic_y", y, 32'h0002_4000);
        check("basic_last", l, 0);

        // Backpressure with a write attempt that must be discarded
        send_start(hb, 1'b0, y, l);
        finish_vec(10, 1'b1);
        run_vec(hb, 1, y, l);
        check("weights_kept_after_drop", y, 32'h0002_4000);

        // Vector wins over a coincident weight write
        send_start(hb, 1'b1, y, l);
        finish_vec(0, 1'b0);
        run_vec(hb, 0, y, l);
        check("weights_kept_vs_hvalid", y, 32'h0002_4000);

        // Rounding: exactly one half rounds up, just below half rounds down
        wr(0, 32'h0000_0001, 1'b0);
        wr(1, 32'h0, 1'b0);
        wr(2, 32'h0, 1'b0);
        wr(3, 32'h0, 1'b0);
        run_vec(pack3(32'h0000_8000, 0, 0), 0, y, l);
        check("round_half_up", y, 32'h0000_0001);
        run_vec(pack3(32'h0000_7FFF, 0, 0), 0, y, l);
        check("round_below_half", y, 32'h0000_0000);

        // Saturation both ways
        wr(0, 32'h7FFF_0000, 1'b0);
        check("model_sat_pos", model_y(pack3(32'h7FFF_0000, 0, 0)), 32'h7FFF_FFFF);
        run_vec(pack3(32'h7FFF_0000, 0, 0), 2, y, l);
        check("sat_pos", y, 32'h7FFF_FFFF);
        run_vec(pack3(32'h8000_0000, 0, 0), 0, y, l);
        check("sat_neg", y, 32'h8000_0000);

        // Sequence framing: last only on the 4th result, then restart via clear
        seq_clear();
        for (int i = 0; i < 5; i++) begin
            run_vec(pack3(rand_word(), rand_word(), rand_word()), 0, y, l);
            lasts[i] = l;
        end
        check("seq_last_v3", lasts[2], 0);
        check("seq_last_v4", lasts[3], 1);
        check("seq_last_v5", lasts[4], 0);
        seq_clear();
        for (int i = 0; i < 2; i++) run_vec(pack3(rand_word(), 0, 0), 0, y, l);
        seq_clear();
        for (int i = 0; i < 4; i++) run_vec(pack3(rand_word(), 0, 0), 0, y, l);
        check("seq_last_after_clear", l, 1);

        // Randomized traffic
        for (int v = 0; v < 40; v++) begin
            int nw, d;
            nw = $urandom_range(0, 2);
            for (int j = 0; j < nw; j++) begin
                wr($urandom_range(0, NU), ($urandom_range(0, 4) == 0) ? $urandom : rand_word(),
                   1'b0);
            end
            if ($urandom_range(0, 7) == 0) seq_clear();
            send_start(pack3(rand_word(), rand_word(), rand_word()),
                       $urandom_range(0, 7) == 0, y, l);
            d = $urandom_range(0, 4);
            finish_vec(d, d > 2);
        end

        // Reset while the MAC is on its second term
        wr(0, 32'h0003_0000, 1'b0);
        i_h_valid = 1'b1;
        i_h_flat  = pack3(32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
        tick();
        i_h_valid = 1'b0;
        tick();
        rstn = 1'b0;
        #1;
        model_reset();
        check("midrst_h_ready", o_h_ready, 1);
        check("midrst_y_valid", o_y_valid, 0);
        check("midrst_y_data", o_y_data, 0);
        check("midrst_y_last", o_y_last, 0);
        check("midrst_w_drop", o_w_drop, 0);
        check("midrst_busy", o_busy, 0);
        tick();
        rstn = 1'b1;
        tick();
        run_vec(pack3(32'h0001_0000, 32'h0002_0000, 32'h0003_0000), 0, y, l);
        check("after_rst_no_weights", y, 32'h0000_0000);
        check("after_rst_last", l, 0);

        tick();
        check("no_pending_results", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
